// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard
// ----------------------
// Register-hazard scoreboard that sits beside the ID stage of the 32-bit
// MIPS pipeline. It tracks in-flight register writes from issue to writeback
// and stalls decode on read-after-write hazards.
//
// Optional feature macro: MIPS_SB_FORWARD_EN
//   defined   - forwarding rules. Only a load-use on slot 0 stalls, and
//               fwd_a_sel/fwd_b_sel drive the bypass muxes.
//   undefined - full interlock. Forward selects are tied to 0 and is_load
//               is ignored.
//
// Ports
//   clk1                 single clock, rising edge
//   rst                  synchronous, active-high reset
//   issue_valid          ID holds an instruction wanting to issue
//   src_a, src_b         source register indices
//   use_a, use_b         the corresponding source is actually read
//   dst, dst_we          destination register index and its write enable
//   is_load              the instruction is a load
//   stall                hold ID/IF this cycle (combinational)
//   issue_fire           issue_valid & ~stall (combinational)
//   busy_mask            registers with a pending write not yet visible
//   fwd_a_sel, fwd_b_sel 0 = register file, k = forward from slot k-1
//   stall_count          saturating count of stall cycles
module mips_hazard_scoreboard #(
   parameter int NREGS  = 32,
   parameter int WB_LAT = 4,
   parameter int AW     = $clog2(NREGS),
   parameter int SW     = $clog2(WB_LAT + 1)
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [AW-1:0]     src_a,
   input  logic [AW-1:0]     src_b,
   input  logic              use_a,
   input  logic              use_b,
   input  logic [AW-1:0]     dst,
   input  logic              dst_we,
   input  logic              is_load,
   output logic              stall,
   output logic              issue_fire,
   output logic [NREGS-1:0]  busy_mask,
   output logic [SW-1:0]     fwd_a_sel,
   output logic [SW-1:0]     fwd_b_sel,
   output logic [15:0]       stall_count
);

   // Slot k holds the instruction issued k+1 cycles ago; slot WB_LAT-1 is in writeback.
   logic [WB_LAT-1:0] slot_valid_r;
   logic [AW-1:0]     slot_dst_r [WB_LAT];
   logic [15:0]       stall_count_r;

   logic [WB_LAT-1:0] match_a_s;
   logic [WB_LAT-1:0] match_b_s;
   logic [NREGS-1:0]  busy_s;
   logic              hazard_s;

`ifdef MIPS_SB_FORWARD_EN
   // Only slot 0 needs its load flag: loads are forwardable from slot 1 onward.
   logic              slot0_load_r;

   // Youngest (lowest k) matching slot wins; result is k+1, or 0 when nothing matches.
   function automatic logic [SW-1:0] youngest_sel(input logic [WB_LAT-1:0] m);
      logic [SW-1:0] sel;
      sel = {SW{1'b0}};
      for (int k = WB_LAT - 1; k >= 0; k--) begin
         if (m[k]) begin
            sel = SW'(k + 1);
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction
`else
   logic              unused_s;
   assign unused_s = ^{is_load, match_a_s[WB_LAT-1], match_b_s[WB_LAT-1]};
`endif

   // Per-slot source matches and the busy mask (writeback slot excluded: write-through).
   always_comb begin
      match_a_s = {WB_LAT{1'b0}};
      match_b_s = {WB_LAT{1'b0}};
      busy_s    = {NREGS{1'b0}};
      for (int k = 0; k < WB_LAT; k++) begin
         if (slot_valid_r[k] && use_a && (src_a != {AW{1'b0}}) && (slot_dst_r[k] == src_a)) begin
            match_a_s[k] = 1'b1;
         end else begin
            match_a_s[k] = 1'b0;
         end
         if (slot_valid_r[k] && use_b && (src_b != {AW{1'b0}}) && (slot_dst_r[k] == src_b)) begin
            match_b_s[k] = 1'b1;
         end else begin
            match_b_s[k] = 1'b0;
         end
         if ((k < WB_LAT - 1) && slot_valid_r[k]) begin
            busy_s[slot_dst_r[k]] = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   // Hazard decision and forward selects.
   always_comb begin
`ifdef MIPS_SB_FORWARD_EN
      hazard_s  = (match_a_s[0] | match_b_s[0]) & slot0_load_r;
      fwd_a_sel = youngest_sel(match_a_s);
      fwd_b_sel = youngest_sel(match_b_s);
`else
      hazard_s  = |(match_a_s[WB_LAT-2:0] | match_b_s[WB_LAT-2:0]);
      fwd_a_sel = {SW{1'b0}};
      fwd_b_sel = {SW{1'b0}};
`endif
   end

   assign stall       = issue_valid & hazard_s;
   assign issue_fire  = issue_valid & ~hazard_s;
   assign busy_mask   = busy_s;
   assign stall_count = stall_count_r;

   // Slot shift pipeline and saturating stall counter; rst wins over a firing issue.
   always_ff @(posedge clk1) begin
      if (rst) begin
         slot_valid_r  <= {WB_LAT{1'b0}};
         stall_count_r <= 16'h0000;
         for (int k = 0; k < WB_LAT; k++) begin
            slot_dst_r[k] <= {AW{1'b0}};
         end
`ifdef MIPS_SB_FORWARD_EN
         slot0_load_r  <= 1'b0;
`endif
      end else begin
         // A stalled cycle loads a bubble so the hazard always drains.
         slot_valid_r  <= {slot_valid_r[WB_LAT-2:0],
                           issue_fire & dst_we & (dst != {AW{1'b0}})};
         slot_dst_r[0] <= dst;
         for (int k = 1; k < WB_LAT; k++) begin
            slot_dst_r[k] <= slot_dst_r[k-1];
         end
`ifdef MIPS_SB_FORWARD_EN
         slot0_load_r  <= is_load;
`endif
         if (stall && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
         end else begin
            stall_count_r <= stall_count_r;
         end
      end
   end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Self-checking bench for mips_hazard_scoreboard. A driver issues directed and
// random instructions, predicts every output from a history of issued writes
// (indexed by cycle number) and queues the prediction; a negedge monitor pops
// and compares. A second instance with a long writeback latency exercises
// stall_count saturation in parallel.
module tb_mips_hazard_scoreboard;

   localparam int NR   = 8;
   localparam int WL   = 4;
   localparam int AW   = 3;
   localparam int SW   = 3;
   localparam int WL_S = 64;
   localparam int SW_S = 7;
`ifdef MIPS_SB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   logic          rst, issue_valid, use_a, use_b, dst_we, is_load;
   logic [AW-1:0] src_a, src_b, dst;
   logic          stall, issue_fire;
   logic [NR-1:0] busy_mask;
   logic [SW-1:0] fwd_a_sel, fwd_b_sel;
   logic [15:0]   stall_count;

   mips_hazard_scoreboard #(.NREGS(NR), .WB_LAT(WL)) u_dut (
      .clk1(clk1), .rst(rst), .issue_valid(issue_valid),
      .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
      .dst(dst), .dst_we(dst_we), .is_load(is_load),
      .stall(stall), .issue_fire(issue_fire), .busy_mask(busy_mask),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
   );

   // Saturation instance: one instruction r1 <- f(r1) offered every cycle.
   logic            s_rst;
   logic            s_stall, s_fire;
   logic [NR-1:0]   s_busy;
   logic [SW_S-1:0] s_sela, s_selb;
   logic [15:0]     s_count;

   mips_hazard_scoreboard #(.NREGS(NR), .WB_LAT(WL_S)) u_sat (
      .clk1(clk1), .rst(s_rst), .issue_valid(1'b1),
      .src_a(3'd1), .src_b(3'd0), .use_a(1'b1), .use_b(1'b0),
      .dst(3'd1), .dst_we(1'b1), .is_load(1'b1),
      .stall(s_stall), .issue_fire(s_fire), .busy_mask(s_busy),
      .fwd_a_sel(s_sela), .fwd_b_sel(s_selb), .stall_count(s_count)
   );

   typedef struct {
      bit            stall;
      bit            fire;
      logic [NR-1:0] busy;
      int            sela;
      int            selb;
      int            cnt;
      bit            chk_sel;
   } exp_t;

   typedef struct {
      int cyc;
      int dst;
      bit ld;
   } wr_t;

   exp_t exp_q[$];
   wr_t  hist[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   cnt_m = 0;
   bit   done_sat = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Age (cycles since issue) of the youngest in-flight write to s, 0 if none.
   function automatic int youngest_age(int s, bit use_s);
      int best = 0;
      if (!use_s || s == 0) return 0;
      foreach (hist[i]) begin
         int age = cyc - hist[i].cyc;
         if (age >= 1 && age <= WL && hist[i].dst == s && (best == 0 || age < best))
            best = age;
      end
      return best;
   endfunction

   function automatic bit load_at_age1();
      foreach (hist[i])
         if (cyc - hist[i].cyc == 1) return hist[i].ld;
      return 1'b0;
   endfunction

   // Called at posedge+1: apply one cycle of stimulus, queue the prediction,
   // then advance the model across the next edge.
   task automatic drive(input bit r, input bit iv, input int sa, input bit ua,
                        input int sb, input bit ub, input int d, input bit we,
                        input bit ld, output bit fired);
      exp_t e;
      int   da, db;
      bit   haz;
      rst = r; issue_valid = iv; src_a = AW'(sa); use_a = ua;
      src_b = AW'(sb); use_b = ub; dst = AW'(d); dst_we = we; is_load = ld;
      da = youngest_age(sa, ua);
      db = youngest_age(sb, ub);
      if (FWD) haz = (da == 1 || db == 1) && load_at_age1();
      else     haz = (da >= 1 && da <= WL - 1) || (db >= 1 && db <= WL - 1);
      e.stall = iv & haz;
      e.fire  = iv & ~haz;
      e.busy  = '0;
      foreach (hist[i])
         if (cyc - hist[i].cyc >= 1 && cyc - hist[i].cyc <= WL - 1) e.busy[hist[i].dst] = 1'b1;
      e.sela    = FWD ? da : 0;
      e.selb    = FWD ? db : 0;
      e.chk_sel = FWD ? e.fire : 1'b1;
      e.cnt     = cnt_m;
      exp_q.push_back(e);
      fired = e.fire;
      @(posedge clk1);
      if (r) begin
         hist.delete();
         cnt_m = 0;
      end else begin
         if (e.stall && cnt_m < 65535) cnt_m++;
         if (e.fire && we && d != 0) hist.push_back('{cyc, d, ld});
      end
      cyc++;
      while (hist.size() > 0 && cyc - hist[0].cyc > WL) void'(hist.pop_front());
      #1;
   endtask

   task automatic idle(input int n);
      bit f;
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, f);
   endtask

   // Offer one instruction and hold it until it fires (bounded).
   task automatic issue(input int sa, input bit ua, input int sb, input bit ub,
                        input int d, input bit we, input bit ld);
      bit f = 1'b0;
      int n = 0;
      while (!f && n < 20) begin
         drive(0, 1, sa, ua, sb, ub, d, we, ld, f);
         n++;
      end
      if (!f) begin
         tests++; fails++;
         $display("FAIL issue_timeout at t=%0t: instruction never fired", $time);
      end
   endtask

   // Monitor: compare the queued prediction with the DUT mid-cycle.
   exp_t m;
   always @(negedge clk1) begin
      if (exp_q.size() > 0) begin
         m = exp_q.pop_front();
         chk("stall", stall, m.stall);
         chk("issue_fire", issue_fire, m.fire);
         chk("busy_mask", busy_mask, m.busy);
         chk("stall_count", stall_count, m.cnt);
         if (m.chk_sel) begin
            chk("fwd_a_sel", fwd_a_sel, m.sela);
            chk("fwd_b_sel", fwd_b_sel, m.selb);
         end
      end
   end

   // Saturation run on the long-latency instance with its own tiny model.
   initial begin : sat_run
      int  c = 0, lf = 0, s_cnt = 0;
      bit  has_lf = 1'b0, stl;
      s_rst = 1'b1;
      @(posedge clk1); #1;
      s_rst = 1'b0;
      for (int i = 0; i < 70100; i++) begin
         stl = has_lf && (FWD ? (c - lf == 1) : (c - lf <= WL_S - 1));
         if (i == 1 || i == 64 || i == 70000 || i == 70099) begin
            chk("sat_stall", s_stall, stl);
            chk("sat_count", s_count, s_cnt);
         end
         @(posedge clk1);
         if (stl) begin
            if (s_cnt < 65535) s_cnt++;
         end else begin
            lf = c;
            has_lf = 1'b1;
         end
         c++;
         #1;
      end
      done_sat = 1'b1;
   end

   initial begin : main_run
      bit f;
      int w;
      rst = 1'b1; issue_valid = 1'b0; use_a = 1'b0; use_b = 1'b0;
      dst_we = 1'b0; is_load = 1'b0; src_a = '0; src_b = '0; dst = '0;
      @(posedge clk1); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, f);
      // Reset state, with issue_valid high.
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, f);
      idle(2);
      // Producer r1 then dependent reader of r1.
      issue(0, 0, 0, 0, 1, 1, 0);
      issue(1, 1, 0, 0, 4, 1, 0);
      idle(5);
      // ALU producer r2, consumer next cycle and two cycles later.
      issue(0, 0, 0, 0, 2, 1, 0);
      issue(2, 1, 0, 0, 0, 0, 0);
      idle(5);
      issue(0, 0, 0, 0, 2, 1, 0);
      idle(1);
      issue(2, 1, 0, 0, 0, 0, 0);
      idle(5);
      // Load r3, consumer on src_b.
      issue(0, 0, 0, 0, 3, 1, 1);
      issue(0, 0, 3, 1, 0, 0, 0);
      idle(5);
      // Register 0 is never busy.
      issue(0, 0, 0, 0, 0, 1, 0);
      issue(0, 1, 0, 1, 0, 0, 0);
      idle(5);
      // Two writers of r5, youngest wins.
      issue(0, 0, 0, 0, 5, 1, 0);
      issue(0, 0, 0, 0, 5, 1, 0);
      issue(5, 1, 5, 1, 0, 0, 0);
      idle(5);
      // Three writes in flight, then reset, then an immediate dependent.
      issue(0, 0, 0, 0, 1, 1, 0);
      issue(0, 0, 0, 0, 2, 1, 0);
      issue(0, 0, 0, 0, 3, 1, 0);
      drive(1, 1, 0, 0, 0, 0, 6, 1, 0, f);
      issue(1, 1, 3, 1, 0, 0, 0);
      idle(3);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(63) == 0, $urandom_range(3) != 0,
               $urandom_range(NR - 1), $urandom_range(1),
               $urandom_range(NR - 1), $urandom_range(1),
               $urandom_range(NR - 1), $urandom_range(3) != 0,
               $urandom_range(2) == 0, f);
      end
      idle(2);
      w = 0;
      while (!done_sat && w < 80000) begin
         @(posedge clk1);
         w++;
      end
      if (!done_sat) begin
         tests++; fails++;
         $display("FAIL sat_timeout: saturation run did not complete");
      end
      @(negedge clk1); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
